// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and operation types for the RAM arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        OP_FETCH,
        OP_READ,
        OP_WRITE
    } arb_op_t;

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - access-cycle counter flagging the last RAM cycle
module arb_wait_counter #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic nRST,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(LAT - 1);

    logic [CW-1:0] count;

    // count access cycles; cleared while the arbiter waits for a grant
    always_ff @(posedge clk) begin
        if (nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-latency data-first arbiter for the shared RAM
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    input  logic          d_ren,
    input  logic          d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_ren,
    output logic          ram_wen,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    arb_state_t state;
    arb_op_t    op;
    logic       cnt_clear;
    logic       cnt_en;
    logic       cnt_done;

    assign cnt_clear = (state == IDLE);
    assign cnt_en    = (state == FETCH) || (state == DATA);

    arb_wait_counter #(
        .LAT (LAT)
    ) u_wait (
        .clk   (clk),
        .nRST  (nRST),
        .clear (cnt_clear),
        .en    (cnt_en),
        .done  (cnt_done)
    );

    // arbitration FSM; ram_addr/ram_wdata double as the latched request
    always_ff @(posedge clk) begin
        if (nRST) begin
            state     <= IDLE;
            op        <= OP_FETCH;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            ram_addr  <= '0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_wdata <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_ren || d_wen) begin
                        // a simultaneous read and write resolves to a write
                        state     <= DATA;
                        op        <= d_wen ? OP_WRITE : OP_READ;
                        ram_addr  <= d_addr;
                        ram_wdata <= d_wdata;
                        ram_ren   <= ~d_wen;
                        ram_wen   <= d_wen;
                    end else if (i_req) begin
                        state     <= FETCH;
                        op        <= OP_FETCH;
                        ram_addr  <= i_addr;
                        ram_wdata <= '0;
                        ram_ren   <= 1'b1;
                        ram_wen   <= 1'b0;
                    end
                end
                FETCH, DATA: begin
                    if (cnt_done) begin
                        state   <= RESP;
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        if (op == OP_FETCH) begin
                            i_rdata <= ram_rdata;
                            i_ready <= 1'b1;
                        end else begin
                            d_ready <= 1'b1;
                            if (op == OP_READ) begin
                                d_rdata <= ram_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Fixed-latency arbiter that shares the single-port instruction/data RAM between the PC fetch path and the load/store path. It sits between `pc`/`control` and `ram_wrapper`. It grants one requester at a time and latches that requester's address and write data. It drives the RAM for `LAT` cycles and returns a one-cycle ready pulse with registered read data. Data accesses take priority over fetches, so the current instruction's load/store always completes before the next fetch.

## Interface
- `LAT`, default 2: RAM access latency in cycles; legal range 1..15.
- `AW`, default 32: address width.
- `DW`, default 32: data width.

- `clk`  input  1  system clock; all state updates on its rising edge.
- `nRST`  input  1  synchronous reset, active-high: a value of 1 at a rising edge resets the block.
- `i_req`  input  1  fetch request; held until `i_ready`.
- `i_addr`  input  AW  fetch address (PC).
- `i_ready`  output  1  one-cycle pulse: the fetch is complete and `i_rdata` is valid.
- `i_rdata`  output  DW  fetched instruction; holds its value until the next fetch completes.
- `d_ren`  input  1  data read request; held until `d_ready`.
- `d_wen`  input  1  data write request; held until `d_ready`.
- `d_addr`  input  AW  data address (ALU result).
- `d_wdata`  input  DW  store data (rs2).
- `d_ready`  output  1  one-cycle pulse: the data access is complete.
- `d_rdata`  output  DW  load data; updated only by completed reads.
- `ram_addr`  output  AW  RAM address.
- `ram_ren`  output  1  RAM read enable.
- `ram_wen`  output  1  RAM write enable.
- `ram_wdata`  output  DW  RAM write data.
- `ram_rdata`  input  DW  RAM read data; valid in the last access cycle.

## Operation
- The FSM has four states: IDLE, FETCH, DATA, RESP.
- IDLE:
  - If `d_ren|d_wen`, go to DATA.
  - Else if `i_req`, go to FETCH.
  - Else stay in IDLE.
  - On a grant, latch the address, write data and op into internal registers and clear the cycle counter.
- FETCH/DATA:
  - Drive `ram_addr` and `ram_wdata` from the latched registers.
  - `ram_ren` is 1 for fetches and data reads; `ram_wen` is 1 only for data writes.
  - Requester inputs may change freely during the access; they are ignored.
  - The counter increments every cycle.
  - When the counter reaches `LAT-1`: capture `ram_rdata` into `i_rdata` (fetch) or `d_rdata` (read), then go to RESP.
- RESP:
  - Assert `i_ready` or `d_ready` (whichever requester was granted) for exactly this cycle.
  - `ram_ren`/`ram_wen` are 0.
  - Next state is always IDLE.
- A requester must drop its request in the cycle after it sees ready. Any request seen in IDLE is treated as a new request.
- If `d_ren` and `d_wen` are both high, the access is a write. `d_rdata` is unchanged.
- Writes pulse `d_ready` and leave `d_rdata` unchanged.
- Arbitration is fixed priority with data first. There is no fairness counter: data requests occur at most once per instruction, so fetch cannot starve.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - All outputs are 0: `i_ready`, `d_ready`, `i_rdata`, `d_rdata`, `ram_addr`, `ram_ren`, `ram_wen`, `ram_wdata`.
- Latency from a request sampled in IDLE (cycle 0):
  - RAM enables are high in cycles 1..LAT.
  - Ready is high in cycle LAT+1.
  - The next grant is possible in cycle LAT+2.
  - Throughput is one access per LAT+2 cycles.
- `LAT=1`: FETCH/DATA lasts one cycle; capture and the transition to RESP happen in that same cycle.
- All outputs are registered, or decoded from registered state/latches only. There is no combinational path from request inputs to any output.
- Reset mid-access: the next edge returns the FSM to IDLE. No ready pulse is issued, the enables drop, and read data registers clear to 0.
- Simultaneous `i_req` and data request in IDLE: data is granted; `i_req` stays pending and is granted at the IDLE cycle following data's RESP.
- A request that rises during FETCH, DATA or RESP is not seen until IDLE.

## Structure
- Package `mem_arb_pkg`: the `arb_state_t` enum (IDLE, FETCH, DATA, RESP) and the `arb_op_t` enum (OP_FETCH, OP_READ, OP_WRITE).
- Counter width is `$clog2(LAT+1)`, computed locally.
- One sub-module, `arb_wait_counter`:
  - Inputs: `clk`, `nRST`, `clear`, `en`.
  - Output: `done` when count == `LAT-1`.
  - Parameterised by `LAT`.
- The FSM, input latches and read-data registers live in `mem_arbiter`.

## Test plan
- Reset: hold `nRST`=1 for 2 cycles, with `i_req`=1 -> all outputs 0, no RAM enables. Release -> `ram_ren`=1 one cycle later.
- Single fetch (LAT=2): `i_req`, `i_addr`=0x40, RAM returns 0x00500093 -> `ram_ren` high in cycles 1–2 with `ram_addr`=0x40; `i_ready` pulses in cycle 3; `i_rdata`=0x00500093.
- Store: `d_wen`, `d_addr`=0x100, `d_wdata`=0xDEADBEEF -> `ram_wen` high for 2 cycles with that address and data; `d_ready` pulse; `d_rdata` unchanged.
- Contention: `i_req` and `d_ren` both high in IDLE -> data served first (`d_ready` cycle 3); fetch then granted, with `i_ready` in cycle 7.
- Input churn: change `i_addr` 0x40 -> 0x80 during FETCH -> `ram_addr` stays 0x40 for the whole access.
- Reset mid-access: assert `nRST` in cycle 1 of DATA -> no `d_ready`, state IDLE, enables 0 next cycle. With LAT=1, a fetch then completes with `i_ready` in cycle 2.
